// File: rtl/lut_psum_accumulator.sv
// rtl/lut_psum_accumulator.sv - saturating accumulator of LUT partial sums
// Sums a programmed number of signed 16-bit psums and offers the result over valid/ready.
module lut_psum_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  input  logic [15:0]      psum_i,
  input  logic             psum_valid_i,
  output logic             psum_ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             start_ok;
  logic             beat;
  logic             last_beat;
  logic [ACC_W:0]   sum;
  logic             sat_hi;
  logic             sat_lo;
  logic [ACC_W-1:0] sum_sat;

  assign beat      = (state == ACCUM) && psum_valid_i;
  assign last_beat = (cnt == len_q - CNT_W'(1));

  // One guard bit above the accumulator makes both overflow directions visible.
  assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){psum_i[15]}}, psum_i};
  assign sat_hi  = ~sum[ACC_W] & sum[ACC_W-1];
  assign sat_lo  = sum[ACC_W] & ~sum[ACC_W-1];
  assign sum_sat = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : sum[ACC_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs depend on state only, never on psum_valid_i or acc_ready_i.
  always_comb begin
    state_nxt    = state;
    psum_ready_o = 1'b0;
    acc_valid_o  = 1'b0;
    start_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_ok  = 1'b1;
          state_nxt = (len_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        psum_ready_o = 1'b1;
        if (psum_valid_i && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        acc_valid_o = 1'b1;
        if (acc_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (start_ok) begin
      len_q <= len_i;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc <= sum_sat;
      cnt <= cnt + CNT_W'(1);
      if (sat_hi || sat_lo) begin
        ovf <= 1'b1;
      end
    end
  end

  assign busy_o = (state != IDLE);
  assign acc_o  = acc;
  assign ovf_o  = ovf;

endmodule

// File: tb/tb_lut_psum_accumulator.sv
// tb/tb_lut_psum_accumulator.sv - directed vector bench for lut_psum_accumulator
// Runs a 32-bit and a 17-bit instance in lockstep on the same stimulus.
module tb_lut_psum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  len;
  logic [15:0] psum;
  logic        psum_valid;
  logic        acc_ready;

  logic        busy32, ready32, valid32, ovf32;
  logic [31:0] acc32;
  logic        busy17, ready17, valid17, ovf17;
  logic [16:0] acc17;

  int n_vec;
  int n_bad;

  lut_psum_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
    .busy_o       (busy32),
    .psum_i       (psum),
    .psum_valid_i (psum_valid),
    .psum_ready_o (ready32),
    .acc_o        (acc32),
    .acc_valid_o  (valid32),
    .acc_ready_i  (acc_ready),
    .ovf_o        (ovf32)
  );

  lut_psum_accumulator #(.ACC_W(17), .CNT_W(10)) dut17 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
    .busy_o       (busy17),
    .psum_i       (psum),
    .psum_valid_i (psum_valid),
    .psum_ready_o (ready17),
    .acc_o        (acc17),
    .acc_valid_o  (valid17),
    .acc_ready_i  (acc_ready),
    .ovf_o        (ovf17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]       len;
    logic [4:0][15:0] ps;
    logic [63:0]      exp32;
    logic             ovf32;
    logic [63:0]      exp17;
    logic             ovf17;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input int l, input int p0, input int p1, input int p2,
                              input int p3, input int p4, input longint e32, input int o32,
                              input longint e17, input int o17);
    vec_t v;
    v.len   = 10'(l);
    v.ps[0] = 16'(p0);
    v.ps[1] = 16'(p1);
    v.ps[2] = 16'(p2);
    v.ps[3] = 16'(p3);
    v.ps[4] = 16'(p4);
    v.exp32 = e32;
    v.ovf32 = o32[0];
    v.exp17 = e17;
    v.ovf17 = o17[0];
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint s32(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint s17(input logic [16:0] x);
    return longint'($signed(x));
  endfunction

  task automatic check_idle(input string nm);
    check({nm, "_acc32"}, s32(acc32), 0);
    check({nm, "_acc17"}, s17(acc17), 0);
    check({nm, "_busy"}, longint'(busy32), 0);
    check({nm, "_ready"}, longint'(ready32), 0);
    check({nm, "_valid"}, longint'(valid32), 0);
    check({nm, "_ovf"}, longint'(ovf32 | ovf17), 0);
  endtask

  // Caller must be at a negedge in IDLE; returns at the negedge after the result transfer.
  task automatic run_job(input int id, input vec_t v);
    int  k;
    int  idx;
    bit  got;
    string tag;
    tag = $sformatf("job%0d", id);
    start = 1'b1;
    len   = v.len;
    psum_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    idx = 0;
    got = 1'b0;
    if (v.len != 0) check({tag, "_ready_t1"}, longint'(ready32), 1);
    while (!got && k <= int'(v.len) + 4) begin
      if (valid32) begin
        got = 1'b1;
      end else begin
        if (ready32 && idx < int'(v.len)) begin
          psum = v.ps[idx];
          psum_valid = 1'b1;
          idx++;
        end else begin
          psum_valid = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    psum_valid = 1'b0;
    check({tag, "_done_seen"}, longint'(got), 1);
    check({tag, "_latency"}, longint'(k), (v.len == 0) ? 1 : longint'(v.len) + 1);
    check({tag, "_acc32"}, s32(acc32), $signed(v.exp32));
    check({tag, "_ovf32"}, longint'(ovf32), longint'(v.ovf32));
    check({tag, "_valid17"}, longint'(valid17), 1);
    check({tag, "_acc17"}, s17(acc17), $signed(v.exp17));
    check({tag, "_ovf17"}, longint'(ovf17), longint'(v.ovf17));
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check({tag, "_idle_busy"}, longint'(busy32), 0);
    check({tag, "_idle_valid"}, longint'(valid32), 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    psum = '0;
    psum_valid = 1'b0;
    acc_ready = 1'b0;

    tbl[0] = mk(4, 100, -50, 7, 32767, 0, 32824, 0, 32824, 0);
    tbl[1] = mk(3, 32767, 32767, 32767, 0, 0, 98301, 0, 65535, 1);
    tbl[2] = mk(1, 5, 0, 0, 0, 0, 5, 0, 5, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(5, 1000, -2000, 3000, -4000, 5000, 3000, 0, 3000, 0);
    tbl[5] = mk(2, -32768, -32768, 0, 0, 0, -65536, 0, -65536, 0);
    tbl[6] = mk(3, -32768, -32768, -32768, 0, 0, -98304, 0, -65536, 1);

    // Reset with random inputs, including start pulses that must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'($urandom_range(0, 1));
      len = 10'($urandom_range(0, 1023));
      psum = 16'($urandom);
      psum_valid = 1'($urandom_range(0, 1));
      acc_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    start = 1'b0;
    psum_valid = 1'b0;
    acc_ready = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_job(i, tbl[i]);
    end

    // Overflow flag stays set in IDLE until a start or reset clears it.
    @(negedge clk);
    check("ovf_sticky", longint'(ovf17), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ovf_reset", longint'(ovf17), 0);
    @(negedge clk);

    // Bubbles on psum_valid, ignored start in ACCUM, then held back-pressure in DONE.
    start = 1'b1;
    len = 10'd3;
    @(negedge clk);
    start = 1'b0;
    psum = 16'hFFFF;
    psum_valid = 1'b1;
    @(negedge clk);
    psum = 16'd1234;
    psum_valid = 1'b0;
    start = 1'b1;
    len = 10'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    psum = 16'hFFFE;
    psum_valid = 1'b1;
    @(negedge clk);
    check("bp_not_done_early", longint'(valid32), 0);
    psum = 16'hFFFD;
    @(negedge clk);
    psum_valid = 1'b0;
    check("bp_valid", longint'(valid32), 1);
    check("bp_acc", s32(acc32), -6);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = 10'd2;
      psum = 16'd999;
      psum_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), longint'(valid32), 1);
      check($sformatf("bp_hold_acc%0d", i), s32(acc32), -6);
    end
    start = 1'b0;
    psum_valid = 1'b0;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check("bp_idle_busy", longint'(busy32), 0);
    check("bp_idle_valid", longint'(valid32), 0);
    check("bp_idle_acc", s32(acc32), -6);

    // Reset in the middle of an 8-beat job discards it.
    start = 1'b1;
    len = 10'd8;
    @(negedge clk);
    start = 1'b0;
    psum = 16'd1000;
    psum_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_partial_acc", s32(acc32), 2000);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    rst_n = 1'b1;
    psum_valid = 1'b0;
    @(negedge clk);
    check_idle("mid_after");
    run_job(7, tbl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
